// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the single-cycle MIPS main decoder.
//   - opcode / funct field constants for the supported instructions
//   - ALU command codes (funct-style encoding)
//   - ctrl_t  : packed control word driven to the datapath
//   - CTRL_NOP: safe word used for reset and for every unsupported instruction
//   - decode(): pure combinational opcode/funct -> control word mapping
// -----------------------------------------------------------------------------
package mips_pkg;

    // Opcode field, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct field, instruction[5:0], only meaningful for OP_RTYPE
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_SYSCALL = 6'b001100;

    // ALU commands share the R-type funct encoding so R-type ALU ops can
    // forward funct straight through.
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    localparam logic [5:0] ALU_NOP = 6'b101100;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump_sel;
        logic       reg_dst;
        logic       wri_data_sel;
        logic [5:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        jump:         1'b0,
        branch:       1'b0,
        mem_read:     1'b0,
        mem_to_reg:   1'b0,
        mem_write:    1'b0,
        alu_src:      1'b0,
        reg_write:    1'b0,
        jump_sel:     1'b0,
        reg_dst:      1'b0,
        wri_data_sel: 1'b0,
        alu_op:       ALU_NOP
    };

    // Every case starts from CTRL_NOP so any field not named stays 0 and any
    // unrecognised opcode/funct falls out as the NOP word.
    function automatic ctrl_t decode(input logic [5:0] opcode,
                                     input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_NOP;
        unique case (opcode)
            OP_LW: begin
                c.mem_read     = 1'b1;
                c.mem_to_reg   = 1'b1;
                c.alu_src      = 1'b1;
                c.reg_write    = 1'b1;
                c.wri_data_sel = 1'b1;
                c.alu_op       = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write    = 1'b1;
                c.alu_src      = 1'b1;
                c.wri_data_sel = 1'b1;
                c.alu_op       = ALU_ADD;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            OP_JAL: begin
                // Link write: destination is $ra, data is PC+link (sel = 0)
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_BNE: begin
                // Taken/not-taken is resolved in the datapath from the
                // subtract result being nonzero.
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_XORI: begin
                c.reg_dst      = 1'b1;
                c.alu_src      = 1'b1;
                c.reg_write    = 1'b1;
                c.wri_data_sel = 1'b1;
                c.alu_op       = ALU_XOR;
            end
            OP_RTYPE: begin
                unique case (funct)
                    F_ADD, F_SUB, F_SLT: begin
                        c.reg_dst      = 1'b1;
                        c.reg_write    = 1'b1;
                        c.wri_data_sel = 1'b1;
                        c.alu_op       = funct;
                    end
                    F_JR: begin
                        c.jump     = 1'b1;
                        c.jump_sel = 1'b1;
                    end
                    default: c = CTRL_NOP; // includes 000000 and SYSCALL
                endcase
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_control.sv
// -----------------------------------------------------------------------------
// mips_control
// Main decoder of the single-cycle MIPS CPU. Opcode/funct are decoded
// combinationally and the full control word is registered, giving one cycle
// of latency from an instruction change to the strobes.
//
// Ports
//   clk        in   CPU clock, rising edge
//   reset_n    in   asynchronous active-low reset, forces the NOP word
//   opcode     in   [5:0] instruction[31:26]
//   funct      in   [5:0] instruction[5:0], used only for R-type
//   Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
//   JumpSel, RegDst, WriDataSel   out  registered 1-bit control strobes
//   ALUOp      out  [5:0] registered ALU command (funct-style encoding)
// -----------------------------------------------------------------------------
module mips_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       Jump,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       JumpSel,
    output logic       RegDst,
    output logic       WriDataSel,
    output logic [5:0] ALUOp
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    always_comb begin
        ctrl_d = decode(opcode, funct);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign Jump       = ctrl_q.jump;
    assign Branch     = ctrl_q.branch;
    assign MemRead    = ctrl_q.mem_read;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign MemWrite   = ctrl_q.mem_write;
    assign ALUSrc     = ctrl_q.alu_src;
    assign RegWrite   = ctrl_q.reg_write;
    assign JumpSel    = ctrl_q.jump_sel;
    assign RegDst     = ctrl_q.reg_dst;
    assign WriDataSel = ctrl_q.wri_data_sel;
    assign ALUOp      = ctrl_q.alu_op;

endmodule

// File: tb/tb_mips_control.sv
// -----------------------------------------------------------------------------
// tb_mips_control
// Scoreboard bench for mips_control. The driver applies an instruction on the
// falling edge and queues the expected control word from a per-signal
// reference model; the monitor pops and compares after each rising edge.
// Reset behaviour is exercised directly before the scoreboard is enabled.
// Packed compare word: {Jump,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,
//                       RegWrite,JumpSel,RegDst,WriDataSel,ALUOp[5:0]}
// -----------------------------------------------------------------------------
module tb_mips_control;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Jump, Branch, MemRead, MemtoReg, MemWrite;
    logic       ALUSrc, RegWrite, JumpSel, RegDst, WriDataSel;
    logic [5:0] ALUOp;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_last;

    mips_control dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .funct     (funct),
        .Jump      (Jump),
        .Branch    (Branch),
        .MemRead   (MemRead),
        .MemtoReg  (MemtoReg),
        .MemWrite  (MemWrite),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .JumpSel   (JumpSel),
        .RegDst    (RegDst),
        .WriDataSel(WriDataSel),
        .ALUOp     (ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dut_word();
        return {Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
                RegWrite, JumpSel, RegDst, WriDataSel, ALUOp};
    endfunction

    // Reference: each strobe is the set of instructions that assert it.
    function automatic logic [15:0] model(input logic [5:0] op, input logic [5:0] fn);
        bit is_lw   = (op == 6'o43);
        bit is_sw   = (op == 6'o53);
        bit is_j    = (op == 6'd2);
        bit is_jal  = (op == 6'd3);
        bit is_bne  = (op == 6'd5);
        bit is_xori = (op == 6'd14);
        bit is_alu  = (op == 6'd0) && (fn == 6'd32 || fn == 6'd34 || fn == 6'd42);
        bit is_jr   = (op == 6'd0) && (fn == 6'd8);
        logic [5:0] aop;
        if (is_lw || is_sw)  aop = 6'd32;
        else if (is_bne)     aop = 6'd34;
        else if (is_xori)    aop = 6'd38;
        else if (is_alu)     aop = fn;
        else                 aop = 6'd44;
        return {is_j || is_jal || is_jr,
                is_bne,
                is_lw,
                is_lw,
                is_sw,
                is_lw || is_sw || is_xori,
                is_lw || is_jal || is_xori || is_alu,
                is_jr,
                is_xori || is_alu,
                is_lw || is_sw || is_xori || is_alu,
                aop};
    endfunction

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endfunction

    // Monitor: one compare per rising edge while a word is outstanding.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", dut_word(), e);
                $display("op=%b fn=%b ctrl=%b exp=%b", opcode, funct, dut_word(), e);
                checks++;
                if ((MemRead && MemWrite) || (Jump && Branch)) begin
                    failures++;
                    $display("FAIL exclusive_strobes: got %b required no MemRead&MemWrite or Jump&Branch",
                             dut_word());
                end
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        exp_q.push_back(model(op, fn));
        #1;
        // Output must not move before the next rising edge.
        check("latency_hold", dut_word(), exp_last);
        exp_last = model(op, fn);
    endtask

    logic [5:0] op_pool [8];
    logic [5:0] fn_pool [7];

    initial begin
        logic [15:0] nop_w;
        logic [15:0] lw_w;
        nop_w = 16'b0000000000_101100;
        lw_w  = model(6'o43, 6'd0);

        op_pool = '{6'd0, 6'd2, 6'd3, 6'd5, 6'd14, 6'o43, 6'o53, 6'd0};
        fn_pool = '{6'd32, 6'd34, 6'd42, 6'd8, 6'd12, 6'd0, 6'd38};

        reset_n = 1'b0;
        opcode  = 6'o43;
        funct   = 6'd0;
        repeat (2) @(negedge clk);
        check("reset_state", dut_word(), nop_w);

        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_lw", dut_word(), lw_w);

        // Asynchronous assertion mid-cycle, away from any clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", dut_word(), nop_w);
        @(posedge clk);
        #1;
        check("reset_held", dut_word(), nop_w);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("nop_until_edge", dut_word(), nop_w);
        @(posedge clk);
        #1;
        check("release_lw2", dut_word(), lw_w);

        exp_last = lw_w;
        mon_en   = 1'b1;

        // Directed walk of the decode table and the NOP/illegal cases.
        drive(6'o43, 6'd0);   // LW
        drive(6'o53, 6'd0);   // SW
        drive(6'd2,  6'd0);   // J
        drive(6'd0,  6'd8);   // JR
        drive(6'd3,  6'd0);   // JAL
        drive(6'd5,  6'd0);   // BNE
        drive(6'd14, 6'd0);   // XORI
        drive(6'd0,  6'd32);  // ADD
        drive(6'd0,  6'd34);  // SUB
        drive(6'd0,  6'd42);  // SLT
        drive(6'd0,  6'd0);   // funct 0 -> NOP
        drive(6'd0,  6'd12);  // SYSCALL -> NOP
        drive(6'd63, 6'd0);   // unlisted opcode -> NOP
        drive(6'd5,  6'd32);  // funct ignored for non-R-type
        drive(6'd2,  6'd8);   // J with JR funct still plain J

        // Randomised: biased toward listed encodings, with fully random fields.
        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = op_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            else                           fn = fn_pool[$urandom_range(0, 6)];
            drive(op, fn);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
